// File: rtl/bgctl_pkg.sv
// ---------------------------------------------------------------------------
// bgctl_pkg
// Shared definitions for the bandgap sequencer: the FSM state encoding,
// the Wishbone register word offsets and the CTRL / STATUS bit positions.
// No ports (package).
// ---------------------------------------------------------------------------
package bgctl_pkg;

    // State encoding is visible to software through STATUS[1:0].
    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_STARTUP  = 2'd1,
        ST_READY    = 2'd2,
        ST_COOLDOWN = 2'd3
    } bgctl_state_e;

    // Word offsets, i.e. wbs_adr_i[4:2].
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_SETTLE  = 3'd1;
    localparam logic [2:0] REG_OFFTIME = 3'd2;
    localparam logic [2:0] REG_ONTIME  = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    // CTRL bit indices.
    localparam int CTRL_EN_REQ    = 0;
    localparam int CTRL_DUTY_MODE = 1;
    localparam int CTRL_IRQ_EN    = 2;

    // STATUS bit indices above the 2-bit state field.
    localparam int STATUS_READY    = 2;
    localparam int STATUS_IRQ_PEND = 3;

endpackage

// File: rtl/bandgap_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// bandgap_seq_ctrl_if
// Wishbone slave-port bundle of the bandgap sequencer.
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : strobe, cycle, write enable
//   wbs_sel_i[3:0]                 : byte selects
//   wbs_adr_i[31:0]                : byte address
//   wbs_dat_i[31:0]                : write data
//   wbs_ack_o                      : acknowledge
//   wbs_dat_o[31:0]                : read data
// Modports: master (bus side driving requests), slave (the sequencer).
// ---------------------------------------------------------------------------
interface bandgap_seq_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/bgctl_wb_regs.sv
// ---------------------------------------------------------------------------
// bgctl_wb_regs
// Wishbone decode, single-cycle registered acknowledge and the register
// file of the bandgap sequencer (CTRL, SETTLE, OFFTIME, ONTIME, STATUS).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   wbs                     : Wishbone slave bundle
//   state                   : current sequencer state (read via STATUS)
//   irq_set                 : one-cycle strobe, sets irq_pending
//   en_req, duty_mode,
//   irq_en                  : CTRL fields
//   irq_pending             : sticky ready interrupt flag (W1C)
//   settle, offtime, ontime : interval registers, CNT_W bits each
// ---------------------------------------------------------------------------
module bgctl_wb_regs
    import bgctl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          CNT_W          = 16,
    parameter logic [CNT_W-1:0] SETTLE_DEFAULT = CNT_W'(1000),
    parameter logic [CNT_W-1:0] OFF_DEFAULT    = CNT_W'(100),
    parameter logic [CNT_W-1:0] ON_DEFAULT     = CNT_W'(5000)
) (
    input  logic               clk,
    input  logic               rst_n,
    bandgap_seq_ctrl_if.slave  wbs,
    input  bgctl_state_e       state,
    input  logic               irq_set,
    output logic               en_req,
    output logic               duty_mode,
    output logic               irq_en,
    output logic               irq_pending,
    output logic [CNT_W-1:0]   settle,
    output logic [CNT_W-1:0]   offtime,
    output logic [CNT_W-1:0]   ontime
);

    logic        hit;
    logic        access;
    logic        wr_en;
    logic        w1c_irq;
    logic        ack_q;
    logic [2:0]  word_sel;
    logic [2:0]  ctrl_q;
    logic [31:0] rd_data;
    logic [31:0] dat_q;
    logic        unused_adr;

    assign hit      = (wbs.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign word_sel = wbs.wbs_adr_i[4:2];

    // Blocking a new access in the cycle right after an ack keeps a strobe
    // that is still held high from being acknowledged twice.
    assign access  = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~ack_q;
    assign wr_en   = access & wbs.wbs_we_i;
    assign w1c_irq = wr_en & (word_sel == REG_STATUS) & wbs.wbs_sel_i[0]
                   & wbs.wbs_dat_i[STATUS_IRQ_PEND];

    assign unused_adr = ^wbs.wbs_adr_i[1:0];

    assign en_req    = ctrl_q[CTRL_EN_REQ];
    assign duty_mode = ctrl_q[CTRL_DUTY_MODE];
    assign irq_en    = ctrl_q[CTRL_IRQ_EN];

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

    // Byte-lane merge: only bits whose byte select is set take new data.
    function automatic logic [CNT_W-1:0] merge_bytes(
        input logic [CNT_W-1:0] old_val,
        input logic [31:0]      data,
        input logic [3:0]       sel
    );
        logic [CNT_W-1:0] result;
        result = old_val;
        for (int i = 0; i < CNT_W; i++) begin
            if (sel[i/8]) begin
                result[i] = data[i];
            end
        end
        return result;
    endfunction

    always_comb begin
        rd_data = '0;
        case (word_sel)
            REG_CTRL:    rd_data = {29'd0, ctrl_q};
            REG_SETTLE:  rd_data = 32'(settle);
            REG_OFFTIME: rd_data = 32'(offtime);
            REG_ONTIME:  rd_data = 32'(ontime);
            REG_STATUS:  rd_data = {28'd0, irq_pending, (state == ST_READY), state};
            default:     rd_data = '0;
        endcase
    end

    // Read data is only driven during the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= access;
            dat_q <= (access & ~wbs.wbs_we_i) ? rd_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            settle  <= SETTLE_DEFAULT;
            offtime <= OFF_DEFAULT;
            ontime  <= ON_DEFAULT;
        end else if (wr_en) begin
            case (word_sel)
                REG_CTRL: begin
                    if (wbs.wbs_sel_i[0]) begin
                        ctrl_q <= wbs.wbs_dat_i[2:0];
                    end
                end
                REG_SETTLE:  settle  <= merge_bytes(settle,  wbs.wbs_dat_i, wbs.wbs_sel_i);
                REG_OFFTIME: offtime <= merge_bytes(offtime, wbs.wbs_dat_i, wbs.wbs_sel_i);
                REG_ONTIME:  ontime  <= merge_bytes(ontime,  wbs.wbs_dat_i, wbs.wbs_sel_i);
                default: ;
            endcase
        end
    end

    // A set from the sequencer on the same edge as a software clear wins,
    // so a ready event can never be lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pending <= 1'b0;
        end else if (irq_set) begin
            irq_pending <= 1'b1;
        end else if (w1c_irq) begin
            irq_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/bandgap_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bandgap_seq_ctrl
// Sequencer for the user-area bandgap reference: drives the bandgap enable,
// times the settling interval, flags a valid reference, enforces a minimum
// off-time and optionally duty-cycles the bandgap.
// Ports:
//   wb_clk_i    : system clock
//   wb_rst_ni   : asynchronous active-low reset
//   wbs         : Wishbone slave bundle (32-byte window at BASE_ADDR)
//   bg_en_o     : bandgap macro enable
//   bg_ready_o  : reference settled and valid
//   irq_o       : ready interrupt (irq_pending & irq_en)
// ---------------------------------------------------------------------------
module bandgap_seq_ctrl
    import bgctl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          CNT_W          = 16,
    parameter logic [CNT_W-1:0] SETTLE_DEFAULT = CNT_W'(1000),
    parameter logic [CNT_W-1:0] OFF_DEFAULT    = CNT_W'(100),
    parameter logic [CNT_W-1:0] ON_DEFAULT     = CNT_W'(5000)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    bandgap_seq_ctrl_if.slave wbs,
    output logic              bg_en_o,
    output logic              bg_ready_o,
    output logic              irq_o
);

    logic             en_req;
    logic             duty_mode;
    logic             irq_en;
    logic             irq_pending;
    logic             irq_set;
    logic             cnt_expired;
    logic             bg_en_d;
    logic             bg_ready_d;
    logic [CNT_W-1:0] settle;
    logic [CNT_W-1:0] offtime;
    logic [CNT_W-1:0] ontime;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    bgctl_state_e     state_q;
    bgctl_state_e     state_d;

    bgctl_wb_regs #(
        .BASE_ADDR      (BASE_ADDR),
        .CNT_W          (CNT_W),
        .SETTLE_DEFAULT (SETTLE_DEFAULT),
        .OFF_DEFAULT    (OFF_DEFAULT),
        .ON_DEFAULT     (ON_DEFAULT)
    ) u_regs (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_ni),
        .wbs         (wbs),
        .state       (state_q),
        .irq_set     (irq_set),
        .en_req      (en_req),
        .duty_mode   (duty_mode),
        .irq_en      (irq_en),
        .irq_pending (irq_pending),
        .settle      (settle),
        .offtime     (offtime),
        .ontime      (ontime)
    );

    // Treating 0 like 1 makes a loaded value N last max(N,1) cycles.
    assign cnt_expired = (cnt_q <= CNT_W'(1));

    assign irq_o = irq_pending & irq_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_set = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (en_req) begin
                    state_d = ST_STARTUP;
                    cnt_d   = settle;
                end
            end
            ST_STARTUP: begin
                // Dropping en_req beats a simultaneous settle expiry, so an
                // aborted startup never reports ready.
                if (!en_req) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = offtime;
                end else if (cnt_expired) begin
                    state_d = ST_READY;
                    cnt_d   = ontime;
                    irq_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READY: begin
                // Without duty_mode the on-counter holds, so turning
                // duty_mode on later resumes from where it stopped.
                if (!en_req) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = offtime;
                end else if (duty_mode) begin
                    if (cnt_expired) begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = offtime;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cnt_expired) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Pin outputs come from the next state so they register on the same
    // edge as the state they describe.
    assign bg_en_d    = (state_d == ST_STARTUP) || (state_d == ST_READY);
    assign bg_ready_d = (state_d == ST_READY);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            bg_en_o    <= 1'b0;
            bg_ready_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bg_en_o    <= bg_en_d;
            bg_ready_o <= bg_ready_d;
        end
    end

endmodule

// File: tb/tb_bandgap_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bandgap_seq_ctrl
// Self-checking bench for bandgap_seq_ctrl: register-access vector table,
// hand-written sequences for timing corners, and randomized duty-cycle runs
// compared against an arithmetic period model.
// ---------------------------------------------------------------------------
module tb_bandgap_seq_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic bg_en;
    logic bg_ready;
    logic irq;
    int   checks = 0;
    int   errors = 0;

    bandgap_seq_ctrl_if bus ();

    bandgap_seq_ctrl #(
        .BASE_ADDR      (BASE),
        .CNT_W          (16),
        .SETTLE_DEFAULT (16'd1000),
        .OFF_DEFAULT    (16'd100),
        .ON_DEFAULT     (16'd5000)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs        (bus),
        .bg_en_o    (bg_en),
        .bg_ready_o (bg_ready),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  off;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [24];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic bus_idle();
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
    endtask

    // Returns 1 ns after the ack edge; a missing ack counts as a failure.
    task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [3:0] sel,
                           input logic [31:0] wdata, output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = '0;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = BASE + {24'd0, off};
        bus.wbs_dat_i = wdata;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) begin
                got   = 1'b1;
                rdata = bus.wbs_dat_o;
            end
        end
        bus_idle();
        check_output($sformatf("ack_seen off 0x%02h", off), {31'd0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] data);
        logic [31:0] dummy;
        wb_xfer(1'b1, off, 4'hF, data, dummy);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] data);
        wb_xfer(1'b0, off, 4'hF, 32'd0, data);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [31:0] rd;
        wb_xfer(v.we, v.off, v.sel, v.wdata, rd);
        if (!v.we) begin
            check_output($sformatf("vec%0d rd 0x%02h", idx, v.off), rd, v.exp);
        end
    endtask

    // Disable, let any cooldown finish, and clear the pending interrupt.
    task automatic go_idle();
        wb_write(8'h00, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        wb_write(8'h10, 32'h8);
    endtask

    // Reference model of duty-cycled operation: with effective lengths
    // (0 treated as 1) the enable pattern repeats every s+on+off+1 cycles:
    // s startup, on ready, off cooldown, one OFF cycle. k counts edges after
    // the CTRL ack edge, starting at 1.
    function automatic void duty_expect(input int k, input int s, input int on,
                                        input int off, output logic en, output logic rdy);
        int period;
        int p;
        period = s + on + off + 1;
        p      = (k - 1) % period;
        en     = (p < s + on);
        rdy    = (p >= s) && (p < s + on);
    endfunction

    task automatic run_duty(input int s, input int on, input int off, input int ncyc,
                            input string tag);
        int   se;
        int   one;
        int   offe;
        logic en_exp;
        logic rdy_exp;
        se   = (s < 1) ? 1 : s;
        one  = (on < 1) ? 1 : on;
        offe = (off < 1) ? 1 : off;
        wb_write(8'h04, 32'(s));
        wb_write(8'h0C, 32'(on));
        wb_write(8'h08, 32'(off));
        wb_write(8'h00, 32'h7);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            duty_expect(k, se, one, offe, en_exp, rdy_exp);
            check_output($sformatf("%s en k%0d", tag, k), {31'd0, bg_en}, {31'd0, en_exp});
            check_output($sformatf("%s rdy k%0d", tag, k), {31'd0, bg_ready}, {31'd0, rdy_exp});
            check_output($sformatf("%s irq k%0d", tag, k), {31'd0, irq},
                         {31'd0, (k >= se + 1)});
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          s;
        int          on;
        int          off;

        vecs[0]  = '{1'b0, 8'h00, 4'hF, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 8'h04, 4'hF, 32'h0,         32'd1000};
        vecs[2]  = '{1'b0, 8'h08, 4'hF, 32'h0,         32'd100};
        vecs[3]  = '{1'b0, 8'h0C, 4'hF, 32'h0,         32'd5000};
        vecs[4]  = '{1'b0, 8'h10, 4'hF, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 8'h14, 4'hF, 32'h0,         32'h0};
        vecs[6]  = '{1'b0, 8'h1C, 4'hF, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 8'h04, 4'h1, 32'hABCD_1234, 32'h0};
        vecs[8]  = '{1'b0, 8'h04, 4'hF, 32'h0,         32'h0000_0334};
        vecs[9]  = '{1'b1, 8'h0C, 4'h2, 32'h0000_5500, 32'h0};
        vecs[10] = '{1'b0, 8'h0C, 4'hF, 32'h0,         32'h0000_5588};
        vecs[11] = '{1'b1, 8'h1C, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{1'b0, 8'h1C, 4'hF, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 8'h00, 4'h0, 32'h0000_0007, 32'h0};
        vecs[14] = '{1'b0, 8'h00, 4'hF, 32'h0,         32'h0};
        vecs[15] = '{1'b1, 8'h08, 4'hF, 32'hFFFF_0007, 32'h0};
        vecs[16] = '{1'b0, 8'h08, 4'hF, 32'h0,         32'h7};
        vecs[17] = '{1'b1, 8'h10, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[18] = '{1'b0, 8'h10, 4'hF, 32'h0,         32'h0};
        vecs[19] = '{1'b1, 8'h00, 4'h1, 32'h0000_0006, 32'h0};
        vecs[20] = '{1'b0, 8'h00, 4'hF, 32'h0,         32'h6};
        vecs[21] = '{1'b1, 8'h00, 4'hF, 32'h0,         32'h0};
        vecs[22] = '{1'b0, 8'h00, 4'hF, 32'h0,         32'h0};
        vecs[23] = '{1'b0, 8'h18, 4'hF, 32'h0,         32'h0};

        bus_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst bg_en", {31'd0, bg_en}, 32'd0);
        check_output("rst bg_ready", {31'd0, bg_ready}, 32'd0);
        check_output("rst irq", {31'd0, irq}, 32'd0);
        check_output("rst ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check_output("rst dat", bus.wbs_dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] register access table");
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(vecs[i], i);
        end
        check_output("table bg_en stays low", {31'd0, bg_en}, 32'd0);

        $display("[TB] startup timing and irq");
        wb_write(8'h04, 32'd10);
        wb_write(8'h00, 32'h5);
        check_output("t2 en at ack", {31'd0, bg_en}, 32'd0);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            check_output($sformatf("t2 en k%0d", k), {31'd0, bg_en}, 32'd1);
            check_output($sformatf("t2 rdy k%0d", k), {31'd0, bg_ready}, {31'd0, (k == 11)});
            check_output($sformatf("t2 irq k%0d", k), {31'd0, irq}, {31'd0, (k == 11)});
        end
        wb_read(8'h10, rd);
        check_output("t2 status ready", rd, 32'h0E);
        wb_write(8'h10, 32'h8);
        check_output("t2 irq cleared", {31'd0, irq}, 32'd0);
        wb_read(8'h10, rd);
        check_output("t2 status cleared", rd, 32'h06);

        $display("[TB] disable from ready, cooldown lockout");
        wb_write(8'h08, 32'd4);
        wb_write(8'h00, 32'd0);
        check_output("t3 en at ack", {31'd0, bg_en}, 32'd1);
        check_output("t3 rdy at ack", {31'd0, bg_ready}, 32'd1);
        @(posedge clk); #1;
        check_output("t3 en cooldown", {31'd0, bg_en}, 32'd0);
        check_output("t3 rdy cooldown", {31'd0, bg_ready}, 32'd0);
        wb_write(8'h00, 32'd1);
        for (int j = 3; j <= 6; j++) begin
            @(posedge clk); #1;
            check_output($sformatf("t3 en edge%0d", j), {31'd0, bg_en}, {31'd0, (j == 6)});
        end

        $display("[TB] aborted startup");
        go_idle();
        wb_write(8'h00, 32'd1);
        @(posedge clk); #1;
        wb_write(8'h00, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            check_output($sformatf("t5 en k%0d", k), {31'd0, bg_en}, 32'd0);
            check_output($sformatf("t5 rdy k%0d", k), {31'd0, bg_ready}, 32'd0);
        end
        wb_read(8'h10, rd);
        check_output("t5 status", rd, 32'h0);

        $display("[TB] duty mode fixed pattern");
        go_idle();
        run_duty(3, 5, 2, 33, "t4");

        $display("[TB] duty mode randomized");
        for (int t = 0; t < 8; t++) begin
            s   = int'($urandom_range(0, 6));
            on  = int'($urandom_range(0, 6));
            off = int'($urandom_range(0, 6));
            go_idle();
            run_duty(s, on, off, 30, $sformatf("rnd%0d s%0d on%0d off%0d", t, s, on, off));
        end

        $display("[TB] back-to-back strobes and decode window");
        go_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE + 32'h1C;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            check_output($sformatf("b2b ack e%0d", e), {31'd0, bus.wbs_ack_o}, {31'd0, (e % 2 == 1)});
            check_output($sformatf("b2b dat e%0d", e), bus.wbs_dat_o, 32'd0);
        end
        bus.wbs_adr_i = BASE + 32'h20;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            check_output($sformatf("miss ack e%0d", e), {31'd0, bus.wbs_ack_o}, 32'd0);
        end
        bus_idle();

        $display("[TB] reset while ready");
        @(posedge clk); #1;
        wb_write(8'h04, 32'd2);
        wb_write(8'h00, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_output("rst-mid rdy before", {31'd0, bg_ready}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_output("rst-mid en", {31'd0, bg_en}, 32'd0);
        check_output("rst-mid rdy", {31'd0, bg_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(8'h04, rd);
        check_output("rst-mid settle default", rd, 32'd1000);
        wb_read(8'h00, rd);
        check_output("rst-mid ctrl", rd, 32'd0);
        check_output("rst-mid en after", {31'd0, bg_en}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
